// File: rtl/arcade_input_mapper_if.sv
`default_nettype none
// ============================================================================
// Module  : arcade_input_mapper_if
// Brief   : ioctl download port bundle feeding the arcade input mapper.
// Revision: 1.0 - initial release
// ============================================================================
interface arcade_input_mapper_if;
    logic        ioctl_wr;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;

    modport master (
        output ioctl_wr,
        output ioctl_index,
        output ioctl_addr,
        output ioctl_dout
    );

    modport slave (
        input ioctl_wr,
        input ioctl_index,
        input ioctl_addr,
        input ioctl_dout
    );
endinterface
`default_nettype wire

// File: rtl/arcade_input_mapper.sv
`default_nettype none
// ============================================================================
// Module  : arcade_input_mapper
// Brief   : Keyboard/joystick merge, rotation remap, coin pulse shaping and
//           DIP bank. Optional macro AUTO_COIN_EN makes start also insert coin.
// Revision: 1.0 - initial release
// ============================================================================
module arcade_input_mapper #(
    parameter int PLAYERS    = 2,
    parameter int DIP_BYTES  = 8,
    parameter int COIN_PULSE = 600000
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic [10:0]            ps2_key,
    input  logic [16*PLAYERS-1:0]  joystick,
    input  logic [1:0]             rotate,
    arcade_input_mapper_if.slave   ioctl,
    output logic [PLAYERS-1:0]     p_up,
    output logic [PLAYERS-1:0]     p_down,
    output logic [PLAYERS-1:0]     p_left,
    output logic [PLAYERS-1:0]     p_right,
    output logic [PLAYERS-1:0]     p_fire,
    output logic [PLAYERS-1:0]     p_start,
    output logic [PLAYERS-1:0]     p_coin,
    output logic                   test,
    output logic [8*DIP_BYTES-1:0] dip,
    output logic                   dip_valid
);

    localparam int                 c_CNT_W = (COIN_PULSE > 1) ? $clog2(COIN_PULSE) : 1;
    localparam logic [c_CNT_W-1:0] c_LOAD  = c_CNT_W'(COIN_PULSE - 1);

    localparam int c_K_P1_UP    = 0;
    localparam int c_K_P1_DN    = 1;
    localparam int c_K_P1_LT    = 2;
    localparam int c_K_P1_RT    = 3;
    localparam int c_K_P1_SPACE = 4;
    localparam int c_K_P1_CTRL  = 5;
    localparam int c_K_P1_START = 6;
    localparam int c_K_P1_F1    = 7;
    localparam int c_K_P1_COIN  = 8;
    localparam int c_K_P2_UP    = 9;
    localparam int c_K_P2_DN    = 10;
    localparam int c_K_P2_LT    = 11;
    localparam int c_K_P2_RT    = 12;
    localparam int c_K_P2_FIRE  = 13;
    localparam int c_K_P2_START = 14;
    localparam int c_K_P2_F2    = 15;
    localparam int c_K_P2_COIN  = 16;
    localparam int c_K_TEST     = 17;
    localparam int c_KN         = 18;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PULSE    = 2'd1,
        S_LOCK     = 2'd2,
        S_WAIT_REL = 2'd3
    } coin_state_t;

    logic              r_key_tog;
    logic [c_KN-1:0]   r_keys;
    logic [c_KN-1:0]   w_hit;
    logic              w_kev;
    logic [8:0]        w_code;
    logic              r_test;

    assign w_kev  = ps2_key[10] ^ r_key_tog;
    assign w_code = ps2_key[8:0];

    // Arrow keys ignore the E0 prefix bit; every other key matches all 9 bits.
    always_comb begin
        w_hit               = '0;
        w_hit[c_K_P1_UP]    = (w_code[7:0] == 8'h75);
        w_hit[c_K_P1_DN]    = (w_code[7:0] == 8'h72);
        w_hit[c_K_P1_LT]    = (w_code[7:0] == 8'h6B);
        w_hit[c_K_P1_RT]    = (w_code[7:0] == 8'h74);
        w_hit[c_K_P1_SPACE] = (w_code == 9'h029);
        w_hit[c_K_P1_CTRL]  = (w_code == 9'h014);
        w_hit[c_K_P1_START] = (w_code == 9'h016);
        w_hit[c_K_P1_F1]    = (w_code == 9'h005);
        w_hit[c_K_P1_COIN]  = (w_code == 9'h02E);
        w_hit[c_K_P2_UP]    = (w_code == 9'h02D);
        w_hit[c_K_P2_DN]    = (w_code == 9'h02B);
        w_hit[c_K_P2_LT]    = (w_code == 9'h023);
        w_hit[c_K_P2_RT]    = (w_code == 9'h034);
        w_hit[c_K_P2_FIRE]  = (w_code == 9'h01C);
        w_hit[c_K_P2_START] = (w_code == 9'h01E);
        w_hit[c_K_P2_F2]    = (w_code == 9'h006);
        w_hit[c_K_P2_COIN]  = (w_code == 9'h036);
        w_hit[c_K_TEST]     = (w_code == 9'h02C);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_key_tog <= 1'b0;
            r_keys    <= '0;
            r_test    <= 1'b0;
        end else begin
            r_key_tog <= ps2_key[10];
            if (w_kev) begin
                r_keys <= (r_keys & ~w_hit) | (w_hit & {c_KN{ps2_key[9]}});
            end
            r_test <= r_keys[c_K_TEST];
        end
    end

    assign test = r_test;

    for (genvar p = 0; p < PLAYERS; p++) begin : g_player
        logic               w_kb_up, w_kb_dn, w_kb_lt, w_kb_rt;
        logic               w_kb_fire, w_kb_start, w_kb_coin;
        logic               w_up, w_dn, w_lt, w_rt, w_fire, w_start, w_coin;
        logic               w_o_up, w_o_dn, w_o_lt, w_o_rt;
        logic               r_up, r_dn, r_lt, r_rt, r_fire, r_start;
        logic               r_coin_out, r_coin_prev;
        coin_state_t        r_state, w_state_nxt;
        logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
        logic [15:0]        w_joy;
        logic               w_unused_joy;

        assign w_joy        = joystick[16*p +: 16];
        assign w_unused_joy = ^w_joy[15:7];

        if (p == 0) begin : g_kb_p1
            assign w_kb_up    = r_keys[c_K_P1_UP];
            assign w_kb_dn    = r_keys[c_K_P1_DN];
            assign w_kb_lt    = r_keys[c_K_P1_LT];
            assign w_kb_rt    = r_keys[c_K_P1_RT];
            assign w_kb_fire  = r_keys[c_K_P1_SPACE] | r_keys[c_K_P1_CTRL];
            assign w_kb_start = r_keys[c_K_P1_START] | r_keys[c_K_P1_F1];
            assign w_kb_coin  = r_keys[c_K_P1_COIN];
        end else if (p == 1) begin : g_kb_p2
            assign w_kb_up    = r_keys[c_K_P2_UP];
            assign w_kb_dn    = r_keys[c_K_P2_DN];
            assign w_kb_lt    = r_keys[c_K_P2_LT];
            assign w_kb_rt    = r_keys[c_K_P2_RT];
            assign w_kb_fire  = r_keys[c_K_P2_FIRE];
            assign w_kb_start = r_keys[c_K_P2_START] | r_keys[c_K_P2_F2];
            assign w_kb_coin  = r_keys[c_K_P2_COIN];
        end else begin : g_kb_none
            assign w_kb_up    = 1'b0;
            assign w_kb_dn    = 1'b0;
            assign w_kb_lt    = 1'b0;
            assign w_kb_rt    = 1'b0;
            assign w_kb_fire  = 1'b0;
            assign w_kb_start = 1'b0;
            assign w_kb_coin  = 1'b0;
        end

        assign w_rt    = w_kb_rt    | w_joy[0];
        assign w_lt    = w_kb_lt    | w_joy[1];
        assign w_dn    = w_kb_dn    | w_joy[2];
        assign w_up    = w_kb_up    | w_joy[3];
        assign w_fire  = w_kb_fire  | w_joy[4];
        assign w_start = w_kb_start | w_joy[5];
`ifdef AUTO_COIN_EN
        assign w_coin  = w_kb_coin | w_joy[6] | w_start;
`else
        assign w_coin  = w_kb_coin | w_joy[6];
`endif

        always_comb begin
            w_o_up = w_up;
            w_o_dn = w_dn;
            w_o_lt = w_lt;
            w_o_rt = w_rt;
            case (rotate)
                2'd1: begin w_o_up = w_lt; w_o_dn = w_rt; w_o_lt = w_dn; w_o_rt = w_up; end
                2'd2: begin w_o_up = w_rt; w_o_dn = w_lt; w_o_lt = w_up; w_o_rt = w_dn; end
                2'd3: begin w_o_up = w_dn; w_o_dn = w_up; w_o_lt = w_rt; w_o_rt = w_lt; end
                default: ;
            endcase
        end

        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                r_up    <= 1'b0;
                r_dn    <= 1'b0;
                r_lt    <= 1'b0;
                r_rt    <= 1'b0;
                r_fire  <= 1'b0;
                r_start <= 1'b0;
            end else begin
                r_up    <= w_o_up;
                r_dn    <= w_o_dn;
                r_lt    <= w_o_lt;
                r_rt    <= w_o_rt;
                r_fire  <= w_fire;
                r_start <= w_start;
            end
        end

        // Only IDLE reacts to a coin edge, so edges seen during PULSE/LOCK are lost.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            case (r_state)
                S_IDLE: begin
                    if (w_coin && !r_coin_prev) begin
                        w_state_nxt = S_PULSE;
                        w_cnt_nxt   = c_LOAD;
                    end
                end
                S_PULSE: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = S_LOCK;
                        w_cnt_nxt   = c_LOAD;
                    end else begin
                        w_cnt_nxt   = r_cnt - 1'b1;
                    end
                end
                S_LOCK: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = w_coin ? S_WAIT_REL : S_IDLE;
                    end else begin
                        w_cnt_nxt   = r_cnt - 1'b1;
                    end
                end
                S_WAIT_REL: begin
                    if (!w_coin) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end

        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                r_state     <= S_IDLE;
                r_cnt       <= '0;
                r_coin_prev <= 1'b0;
                r_coin_out  <= 1'b0;
            end else begin
                r_state     <= w_state_nxt;
                r_cnt       <= w_cnt_nxt;
                r_coin_prev <= w_coin;
                r_coin_out  <= (r_state == S_PULSE);
            end
        end

        assign p_up[p]    = r_up;
        assign p_down[p]  = r_dn;
        assign p_left[p]  = r_lt;
        assign p_right[p] = r_rt;
        assign p_fire[p]  = r_fire;
        assign p_start[p] = r_start;
        assign p_coin[p]  = r_coin_out;
    end

    logic                   w_dip_we;
    logic [8*DIP_BYTES-1:0] r_dip;
    logic                   r_dip_valid;

    assign w_dip_we = ioctl.ioctl_wr && (ioctl.ioctl_index == 8'd254) &&
                      (ioctl.ioctl_addr < 25'(DIP_BYTES));

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_dip       <= '1;
            r_dip_valid <= 1'b0;
        end else if (w_dip_we) begin
            for (int b = 0; b < DIP_BYTES; b++) begin
                if (ioctl.ioctl_addr[2:0] == 3'(b)) begin
                    r_dip[8*b +: 8] <= ioctl.ioctl_dout;
                end
            end
            if (ioctl.ioctl_addr[2:0] == 3'(DIP_BYTES - 1)) begin
                r_dip_valid <= 1'b1;
            end
        end
    end

    assign dip       = r_dip;
    assign dip_valid = r_dip_valid;

endmodule
`default_nettype wire

// File: tb/tb_arcade_input_mapper.sv
`default_nettype none
// ============================================================================
// Module  : tb_arcade_input_mapper
// Brief   : Self-checking bench for arcade_input_mapper (PLAYERS=2, COIN_PULSE=4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_arcade_input_mapper;
    localparam int PLAYERS    = 2;
    localparam int DIP_BYTES  = 8;
    localparam int COIN_PULSE = 4;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] ps2_key = '0;
    logic [31:0] joystick = '0;
    logic [1:0]  rotate = '0;
    logic [1:0]  p_up, p_down, p_left, p_right, p_fire, p_start, p_coin;
    logic        test;
    logic [63:0] dip;
    logic        dip_valid;

    arcade_input_mapper_if ioctl ();

    arcade_input_mapper #(
        .PLAYERS    (PLAYERS),
        .DIP_BYTES  (DIP_BYTES),
        .COIN_PULSE (COIN_PULSE)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ps2_key   (ps2_key),
        .joystick  (joystick),
        .rotate    (rotate),
        .ioctl     (ioctl),
        .p_up      (p_up),
        .p_down    (p_down),
        .p_left    (p_left),
        .p_right   (p_right),
        .p_fire    (p_fire),
        .p_start   (p_start),
        .p_coin    (p_coin),
        .test      (test),
        .dip       (dip),
        .dip_valid (dip_valid)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;
    int highs  = 0;

    bit       pressed [0:511];
    bit [7:0] dipm [0:7];
    bit       dvm;

    // Coin reference for player 2, kept as a timeline of edge numbers.
    int n, ready, decide, pstart;
    bit need_low, prv;

    logic [8:0] codes [0:23] = '{9'h075, 9'h175, 9'h072, 9'h172, 9'h06B, 9'h16B,
                                 9'h074, 9'h174, 9'h029, 9'h014, 9'h016, 9'h005,
                                 9'h02E, 9'h02D, 9'h02B, 9'h023, 9'h034, 9'h01C,
                                 9'h01E, 9'h006, 9'h02C, 9'h114, 9'h01A, 9'h129};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic kev(input bit pr, input logic [8:0] code);
        ps2_key = {~ps2_key[10], pr, code};
        if (code[7:0] inside {8'h75, 8'h72, 8'h6B, 8'h74}) pressed[{1'b0, code[7:0]}] = pr;
        else pressed[code] = pr;
    endtask

    task automatic check_outputs(input string tag);
        logic [1:0] eu, er, ed, el, ef, es;
        int k;
        k = (rotate == 2'd1) ? 1 : (rotate == 2'd2) ? 3 : (rotate == 2'd3) ? 2 : 0;
        for (int p = 0; p < 2; p++) begin
            bit raw [4];
            bit o [4];
            bit fire, start;
            logic [15:0] j;
            j = joystick[16*p +: 16];
            // direction index: 0 up, 1 right, 2 down, 3 left (clockwise order)
            raw[0] = j[3]; raw[1] = j[0]; raw[2] = j[2]; raw[3] = j[1];
            fire = j[4]; start = j[5];
            if (p == 0) begin
                raw[0] |= pressed[9'h075]; raw[1] |= pressed[9'h074];
                raw[2] |= pressed[9'h072]; raw[3] |= pressed[9'h06B];
                fire  |= pressed[9'h029] | pressed[9'h014];
                start |= pressed[9'h016] | pressed[9'h005];
            end else begin
                raw[0] |= pressed[9'h02D]; raw[1] |= pressed[9'h034];
                raw[2] |= pressed[9'h02B]; raw[3] |= pressed[9'h023];
                fire  |= pressed[9'h01C];
                start |= pressed[9'h01E] | pressed[9'h006];
            end
            for (int d = 0; d < 4; d++) o[(d + k) % 4] = raw[d];
            eu[p] = o[0]; er[p] = o[1]; ed[p] = o[2]; el[p] = o[3];
            ef[p] = fire; es[p] = start;
        end
        chk({tag, "_up"},    64'(p_up),    64'(eu));
        chk({tag, "_down"},  64'(p_down),  64'(ed));
        chk({tag, "_left"},  64'(p_left),  64'(el));
        chk({tag, "_right"}, 64'(p_right), 64'(er));
        chk({tag, "_fire"},  64'(p_fire),  64'(ef));
        chk({tag, "_start"}, 64'(p_start), 64'(es));
        chk({tag, "_test"},  64'(test),    64'(pressed[9'h02C]));
    endtask

    function automatic logic [63:0] dip_exp();
        logic [63:0] v;
        for (int b = 0; b < 8; b++) v[8*b +: 8] = dipm[b];
        return v;
    endfunction

    task automatic dip_wr(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
        ioctl.ioctl_wr    = 1'b1;
        ioctl.ioctl_index = idx;
        ioctl.ioctl_addr  = addr;
        ioctl.ioctl_dout  = data;
        if (idx == 8'd254 && addr < 25'd8) begin
            dipm[addr[2:0]] = data;
            if (addr == 25'd7) dvm = 1'b1;
        end
        tick();
        ioctl.ioctl_wr = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 512; i++) pressed[i] = 1'b0;
        for (int b = 0; b < 8; b++) dipm[b] = 8'hFF;
        dvm = 1'b0;
    endtask

    task automatic coin_cycle(input bit r);
        bit e;
        joystick[22] = r;
        @(posedge clk_sys);
        n++;
        if (n == decide) begin
            if (r) need_low = 1'b1;
            else   ready = n + 1;
        end else if (need_low) begin
            if (!r) begin
                need_low = 1'b0;
                ready    = n + 1;
            end
        end else if (n >= ready && r && !prv) begin
            pstart = n;
            decide = n + 2 * COIN_PULSE;
            ready  = decide + 1;
        end
        prv = r;
        #1;
        e = (n >= pstart + 1) && (n <= pstart + COIN_PULSE);
        chk("coin_p2", 64'(p_coin[1]), 64'(e));
        if (p_coin[1]) highs++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        ioctl.ioctl_wr    = 1'b0;
        ioctl.ioctl_index = '0;
        ioctl.ioctl_addr  = '0;
        ioctl.ioctl_dout  = '0;
        model_reset();

        // Reset state
        repeat (3) tick();
        check_outputs("reset");
        chk("reset_coin", 64'(p_coin), 64'd0);
        chk("reset_dip", dip, {64{1'b1}});
        chk("reset_dip_valid", 64'(dip_valid), 64'd0);
        reset_n = 1'b1;
        tick();

        // DIP bank
        dip_wr(8'd254, 25'd2, 8'h5A);
        tick();
        chk("dip_byte2", 64'(dip[23:16]), 64'h5A);
        chk("dip_after_b2", dip, dip_exp());
        chk("dip_valid_early", 64'(dip_valid), 64'(dvm));
        dip_wr(8'd254, 25'd7, 8'h3C);
        tick();
        chk("dip_after_b7", dip, dip_exp());
        chk("dip_valid_set", 64'(dip_valid), 64'(dvm));
        dip_wr(8'd254, 25'd8, 8'h11);
        dip_wr(8'd253, 25'd0, 8'h22);
        tick();
        chk("dip_out_of_range", dip, dip_exp());
        dip_wr(8'd254, 25'd0, 8'hA1);
        dip_wr(8'd254, 25'd1, 8'hB2);
        tick();
        chk("dip_back_to_back", dip, dip_exp());
        for (int i = 0; i < 6; i++) begin
            dip_wr(8'(($urandom_range(0, 3) == 0) ? 253 : 254), 25'($urandom_range(0, 11)), 8'($urandom));
        end
        tick();
        chk("dip_random", dip, dip_exp());
        chk("dip_valid_random", 64'(dip_valid), 64'(dvm));

        // Coin shaper, player 2 via joystick bit 6
        n = 0; ready = 0; decide = -1; pstart = -100; need_low = 1'b0; prv = 1'b0;
        highs = 0;
        repeat (20) coin_cycle(1'b1);
        chk("coin_held_one_pulse", 64'(highs), 64'd4);
        highs = 0;
        repeat (3) coin_cycle(1'b0);
        repeat (6) coin_cycle(1'b1);
        coin_cycle(1'b0);
        repeat (3) coin_cycle(1'b1);
        repeat (3) coin_cycle(1'b0);
        chk("coin_lock_repress", 64'(highs), 64'd4);
        highs = 0;
        repeat (6) coin_cycle(1'b1);
        repeat (6) coin_cycle(1'b0);
        chk("coin_second_pulse", 64'(highs), 64'd4);
        begin
            bit r;
            r = 1'b0;
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(0, 3) == 0) r = ~r;
                coin_cycle(r);
            end
        end
        joystick = '0;
        repeat (12) tick();

        // PS/2 keyboard path
        kev(1'b1, 9'h075);
        tick();
        chk("kb_latency_1", 64'(p_up[0]), 64'd0);
        tick();
        chk("kb_latency_2", 64'(p_up[0]), 64'd1);
        kev(1'b0, 9'h075);
        tick(); tick();
        chk("kb_release", 64'(p_up[0]), 64'd0);
        kev(1'b1, 9'h175);
        tick(); tick();
        chk("kb_extended", 64'(p_up[0]), 64'd1);
        ps2_key = {ps2_key[10], 1'b0, 9'h175};
        tick(); tick();
        chk("kb_no_toggle", 64'(p_up[0]), 64'd1);
        kev(1'b0, 9'h075);
        tick(); tick();
        check_outputs("kb_rel_ext");
        kev(1'b1, 9'h029);
        tick();
        kev(1'b0, 9'h029);
        tick(); tick();
        check_outputs("kb_last_wins");

        // Rotation with P1 joystick up held
        joystick[3] = 1'b1;
        rotate = 2'd0; tick();
        chk("rot0_up", 64'(p_up), 64'd1);
        rotate = 2'd1; tick();
        chk("rot1_right", 64'(p_right), 64'd1);
        rotate = 2'd2; tick();
        chk("rot2_left", 64'(p_left), 64'd1);
        rotate = 2'd3; tick();
        chk("rot3_down", 64'(p_down), 64'd1);
        check_outputs("rot3_all");

        // Randomized merge / remap
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 2))
                0:       kev(1'($urandom), codes[$urandom_range(0, 23)]);
                1:       joystick = $urandom;
                default: rotate = 2'($urandom_range(0, 3));
            endcase
            tick(); tick();
            check_outputs("rand");
        end

        // Reset clears everything
        reset_n = 1'b0;
        joystick = '0;
        rotate = '0;
        model_reset();
        tick(); tick();
        check_outputs("reset2");
        chk("reset2_coin", 64'(p_coin), 64'd0);
        chk("reset2_dip", dip, {64{1'b1}});
        reset_n = 1'b1;
        tick();

        // Start key and automatic coin
        kev(1'b1, 9'h016);
        tick(); tick();
        chk("start_key", 64'(p_start[0]), 64'd1);
        highs = 0;
        repeat (12) begin
            if (p_coin[0]) highs++;
            tick();
        end
`ifdef AUTO_COIN_EN
        chk("auto_coin_pulse", 64'(highs), 64'd4);
`else
        chk("auto_coin_pulse", 64'(highs), 64'd0);
`endif
        kev(1'b0, 9'h016);
        repeat (12) tick();

        // Reset during a coin pulse
        joystick[6] = 1'b1;
        for (int i = 0; i < 10 && !p_coin[0]; i++) tick();
        chk("coin_p1_active", 64'(p_coin[0]), 64'd1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("reset_midpulse", 64'(p_coin[0]), 64'd0);
        chk("reset_midpulse_dip", dip, {64{1'b1}});
        tick();
        reset_n = 1'b1;
        joystick[6] = 1'b0;
        tick(); tick();
        joystick[6] = 1'b1;
        tick();
        chk("coin_latency_1", 64'(p_coin[0]), 64'd0);
        tick();
        chk("coin_latency_2", 64'(p_coin[0]), 64'd1);
        highs = 1;
        repeat (12) begin
            tick();
            if (p_coin[0]) highs++;
        end
        chk("coin_after_reset", 64'(highs), 64'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/arcade_input_mapper.md
# arcade_input_mapper

Parametrised player-input front end for the arcade cores. It sits between `hps_io` and the game core. It merges PS/2 keyboard and joystick inputs for up to four players, remaps directions for screen rotation, and shapes coin requests into fixed-width pulses with lockout. It also holds the DIP-switch bank loaded over the ioctl download path (index 254).

## Interface
Parameters:
- `PLAYERS`, 2 — number of player slots, 1..4.
- `DIP_BYTES`, 8 — DIP bank depth in bytes, 1..8.
- `COIN_PULSE`, 600000 — coin output high time in `clk_sys` cycles (50 ms at 12 MHz). Also the post-pulse lockout time. Minimum 1.

Ports:
- `clk_sys` in 1 — system clock; the only clock.
- `reset_n` in 1 — asynchronous, active-low reset.
- `ps2_key` in 11 — [10] toggles on each event, [9] pressed, [8:0] code ([8] = E0 extended).
- `joystick` in 16*PLAYERS — player p occupies bits [16p+15:16p]. Bit 0 right, 1 left, 2 down, 3 up, 4 fire, 5 start, 6 coin.
- `rotate` in 2 — 0 none, 1 CW, 2 CCW, 3 180°. Sampled every cycle.
- `ioctl_wr` in 1, `ioctl_index` in 8, `ioctl_addr` in 25, `ioctl_dout` in 8 — download port.
- `p_up`, `p_down`, `p_left`, `p_right`, `p_fire`, `p_start`, `p_coin` out PLAYERS each — active-high, registered, one bit per player.
- `test` out 1 — service/test key.
- `dip` out 8*DIP_BYTES — byte n at [8n+7:8n].
- `dip_valid` out 1 — set on the first write to byte DIP_BYTES-1.

## Operation
- **Keyboard edge detect.**
  - `key_tog` register holds the last sampled `ps2_key[10]`.
  - An event is decoded only in a cycle where `ps2_key[10] != key_tog`.
  - On that event the matching key register is loaded with `ps2_key[9]`. Unmatched codes are ignored.
- **Key map.**
  - Arrow codes 75/72/6B/74 match with [8] don't-care.
  - P1: arrows, space 029 or ctrl 014 = fire, 016 = start, 005 (F1) = start, 02E = coin.
  - P2: 02D up, 02B down, 023 left, 034 right, 01C fire, 01E or 006 (F2) start, 036 coin.
  - 02C drives `test`.
  - Players 3..4 have no keyboard keys.
- **Merge.** Each raw logical input is the keyboard register OR the joystick bit.
- **Rotation remap.** Outputs (up, down, left, right) are taken from raw inputs as follows:
  - 0: (up, down, left, right).
  - 1: (left, right, down, up).
  - 2: (right, left, up, down).
  - 3: (down, up, right, left).
  - Fire, start, coin and test are not remapped.
- **Coin shaper.** One per player, states IDLE, PULSE, LOCK, WAIT_REL.
  - IDLE: on a raw coin rising edge, go to PULSE and load the counter with COIN_PULSE-1.
  - PULSE: `p_coin`=1. When the counter reaches 0, go to LOCK and reload with COIN_PULSE-1.
  - LOCK: `p_coin`=0. When the counter reaches 0, go to WAIT_REL if raw coin is still high, otherwise IDLE.
  - WAIT_REL: return to IDLE when raw coin is low.
  - A held coin produces exactly one pulse.
  - Rising edges during PULSE or LOCK are discarded.
  - Counter width is `$clog2(COIN_PULSE)`, minimum 1.
- **DIP bank.**
  - A write occurs when `ioctl_wr && ioctl_index==254 && ioctl_addr < DIP_BYTES`; it stores `ioctl_dout` into byte `ioctl_addr[2:0]`.
  - Writes outside that range are ignored.
  - The bank is not cleared by a new download.

## Timing
- **Reset values.** Asserting `reset_n` low asynchronously forces:
  - all key registers 0, `key_tog` 0;
  - all direction/fire/start outputs 0, `test` 0;
  - coin FSMs to IDLE with `p_coin`=0, counters 0;
  - `dip` all bytes 8'hFF, `dip_valid` 0.
- **Reset mid-pulse.** Reset during PULSE drops `p_coin` immediately; no residual lockout after release.
- **Joystick path.** A joystick change before edge N appears on the outputs after edge N. Latency is 1 cycle.
- **Keyboard path.** A toggle change before edge N updates the key register at N; the output follows at N+1. Latency is 2 cycles.
- **Coin path.**
  - A raw coin rising edge visible at edge N sets `p_coin` after edge N+1.
  - `p_coin` then stays high for exactly COIN_PULSE cycles.
  - It then stays low for at least COIN_PULSE cycles.
- **Rotate change.** Takes effect on the next edge. No glitch filtering.
- **Simultaneous events.**
  - Keyboard and joystick on the same input: OR.
  - Key press and release of the same code in consecutive events: last event wins.
  - Two DIP writes in consecutive cycles: both stored.

## Configuration
- `AUTO_COIN_EN` defined:
  - Raw coin for player p also includes that player's raw start.
  - Pressing start therefore issues one coin pulse as well as `p_start`.
- Undefined: coin comes only from the coin key and joystick bit 6.

## Test plan
- Reset: hold `reset_n` low and check `dip` = all FF, every output 0. Release, then write 254/addr 2/8'h5A → `dip[23:16]`=5A two edges later. Write addr 7 → `dip_valid`=1. Write addr 8 with DIP_BYTES=8 → no change.
- PS/2: toggle [10] with {pressed=1, code 0x075} → `p_up[0]`=1 two cycles later. Repeat with code 0x175 → same. Release event → `p_up[0]`=0. Same toggle value held → no change.
- Rotation: P1 joystick up (bit 3) held:
  - rotate=0 → `p_up[0]`=1.
  - rotate=1 → `p_right[0]`=1.
  - rotate=2 → `p_left[0]`=1.
  - rotate=3 → `p_down[0]`=1.
- Coin, COIN_PULSE=4: hold P2 joystick bit 6 for 20 cycles → `p_coin[1]` high exactly 4 cycles, then low. Release and re-press during LOCK → ignored. Re-press after LOCK → second 4-cycle pulse.
- Reset mid-pulse: assert `reset_n` low while `p_coin[0]`=1 → output 0 in the same cycle. After release, a new edge gives a full 4-cycle pulse.
- `AUTO_COIN_EN`: press key 016 → `p_start[0]`=1 and one 4-cycle `p_coin[0]` pulse. Without the macro → no coin pulse.
